// File: rtl/ipi_irq_ctrl_pkg.sv
// Address map and register selects shared between the IPI block and the per-core
// interrupt controller that sits directly behind it on the same bus segment.
package ipi_irq_ctrl_pkg;

   localparam int ADR_W    = 18;
   localparam int REG_LSB  = 2;
   localparam int REG_MSB  = 3;
   localparam int CORE_LSB = 4;
   localparam int CORE_MSB = 17;
   localparam int CORE_W   = CORE_MSB - CORE_LSB + 1;

   typedef enum logic [1:0] {
      REG_MASK   = 2'd0,
      REG_PEND   = 2'd1,
      REG_MODE   = 2'd2,
      REG_ACTIVE = 2'd3
   } reg_sel_e;

   typedef struct packed {
      logic [CORE_W-1:0] core;
      reg_sel_e          sel;
   } reg_addr_t;

   // Splits the word-aligned part of a byte address into core index and register select.
   function automatic reg_addr_t decode_addr(input logic [CORE_MSB:REG_LSB] adr);
      reg_addr_t a;
      a.core = adr[CORE_MSB:CORE_LSB];
      a.sel  = reg_sel_e'(adr[REG_MSB:REG_LSB]);
      return a;
   endfunction

endpackage

// File: rtl/ipi_irq_sync.sv
// Two-flop synchronizer for asynchronous interrupt lines, followed by a history flop
// so that a one-cycle rise pulse can be derived from the synchronized level.
module ipi_irq_sync #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] hist_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
         hist_q <= '0;
      end else begin
         // NOTE: non-blocking so each stage samples its predecessor's pre-edge value;
         // blocking assignments would collapse the chain into a single flop.
         meta_q <= async_in;
         sync_q <= meta_q;
         hist_q <= sync_q;
      end
   end

   assign level = sync_q;
   assign rise  = sync_q & ~hist_q;

endmodule

// File: rtl/ipi_irq_ctrl.sv
// Per-core interrupt controller: merges each core's IPI with shared peripheral lines,
// applies mask, edge/level mode and pending latches, and drives one registered irq per CPU.
module ipi_irq_ctrl
   import ipi_irq_ctrl_pkg::*;
#(
   parameter int NUM_CORES = 2,
   parameter int NUM_SRC   = 8
) (
   input  logic                 wb_clk,
   input  logic                 wb_rst,
   input  logic [ADR_W-1:0]     wb_adr_i,
   input  logic [31:0]          wb_dat_i,
   input  logic [3:0]           wb_sel_i,
   input  logic                 wb_we_i,
   input  logic                 wb_cyc_i,
   input  logic                 wb_stb_i,
   input  logic [2:0]           wb_cti_i,
   input  logic [1:0]           wb_bte_i,
   output logic [31:0]          wb_dat_o,
   output logic                 wb_ack_o,
   output logic                 wb_err_o,
   output logic                 wb_rty_o,
   input  logic [NUM_CORES-1:0] ipi_irq_i,
   input  logic [NUM_SRC-1:0]   src_irq_i,
   output logic [NUM_CORES-1:0] cpu_irq_o
);

   localparam int W = NUM_SRC + 1;

   logic [NUM_SRC-1:0] src_level;
   logic [NUM_SRC-1:0] src_rise;

   ipi_irq_sync #(
      .WIDTH (NUM_SRC)
   ) u_src_sync (
      .clk      (wb_clk),
      .rst_n    (wb_rst),
      .async_in (src_irq_i),
      .level    (src_level),
      .rise     (src_rise)
   );

   logic [NUM_CORES-1:0][W-1:0] mask_q;
   logic [NUM_CORES-1:0][W-1:0] mode_q;
   logic [NUM_CORES-1:0][W-1:0] pend_q;
   logic [NUM_CORES-1:0][W-1:0] pend_d;
   logic [NUM_CORES-1:0]        irq_q;

   reg_addr_t            addr;
   logic                 req;
   logic                 core_ok;
   logic                 wr;
   logic [NUM_CORES-1:0] core_hit;
   logic [W-1:0]         wdata;
   logic [W-1:0]         rd_vec;
   logic [31:0]          rd_data;
   logic                 ack_q;
   logic                 err_q;
   logic [31:0]          dat_q;

   // ---------------------------------------------------------------------------
   // Bus decode: one response per access, never re-triggered while ack/err is high
   // ---------------------------------------------------------------------------
   assign addr    = decode_addr(wb_adr_i[CORE_MSB:REG_LSB]);
   assign req     = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
   assign core_ok = addr.core < CORE_W'(NUM_CORES);
   assign wr      = req & core_ok & wb_we_i;
   assign wdata   = wb_dat_i[W-1:0];

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can
      // leave it unassigned and infer a latch.
      core_hit = '0;
      for (int c = 0; c < NUM_CORES; c++) begin
         core_hit[c] = (addr.core == CORE_W'(c));
      end
   end

   always_comb begin
      rd_vec = '0;
      for (int c = 0; c < NUM_CORES; c++) begin
         if (core_hit[c]) begin
            unique case (addr.sel)
               REG_MASK:   rd_vec = mask_q[c];
               REG_PEND:   rd_vec = pend_q[c];
               REG_MODE:   rd_vec = mode_q[c];
               REG_ACTIVE: rd_vec = pend_q[c] & mask_q[c];
            endcase
         end
      end
      rd_data          = '0;
      rd_data[W-1:0]   = rd_vec;
   end

   // ---------------------------------------------------------------------------
   // Pending latches. Bit 0 (IPI) is always level; edge bits set on a synchronized
   // rise and clear on W1C, with a coincident rise taking priority.
   // ---------------------------------------------------------------------------
   for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
      logic [W-1:0] lvl;
      logic [W-1:0] rise;
      logic [W-1:0] clr;

      assign lvl  = {src_level, ipi_irq_i[c]};
      assign rise = {src_rise, 1'b0};
      assign clr  = (wr && core_hit[c] && addr.sel == REG_PEND) ? (wdata & mode_q[c]) : '0;

      assign pend_d[c] = (mode_q[c] & ((pend_q[c] & ~clr) | rise))
                       | (~mode_q[c] & lvl);
   end

   always_ff @(posedge wb_clk or negedge wb_rst) begin
      if (!wb_rst) begin
         mask_q <= '0;
         mode_q <= '0;
         pend_q <= '0;
         irq_q  <= '0;
      end else begin
         pend_q <= pend_d;
         for (int c = 0; c < NUM_CORES; c++) begin
            irq_q[c] <= |(pend_q[c] & mask_q[c]);
            if (wr && core_hit[c]) begin
               if (addr.sel == REG_MASK) mask_q[c] <= wdata;
               // The IPI bit cannot be switched to edge mode.
               if (addr.sel == REG_MODE) mode_q[c] <= {wdata[W-1:1], 1'b0};
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Registered bus response
   // ---------------------------------------------------------------------------
   always_ff @(posedge wb_clk or negedge wb_rst) begin
      if (!wb_rst) begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= req & core_ok;
         err_q <= req & ~core_ok;
         if (req) dat_q <= core_ok ? rd_data : '0;
      end
   end

   assign wb_dat_o  = dat_q;
   assign wb_ack_o  = ack_q;
   assign wb_err_o  = err_q;
   assign wb_rty_o  = 1'b0;
   assign cpu_irq_o = irq_q;

   // Byte selects and burst hints carry no meaning here; every access is a full word.
   logic unused;
   assign unused = ^{wb_sel_i, wb_cti_i, wb_bte_i, wb_adr_i[1:0], wb_dat_i};

endmodule

// File: tb/tb_ipi_irq_ctrl.sv
// Self-checking bench for ipi_irq_ctrl: directed scenarios plus a randomized run
// compared cycle by cycle against a rule-based model of the controller.
module tb_ipi_irq_ctrl;

   localparam int NC = 2;
   localparam int NS = 8;
   localparam int W  = NS + 1;

   logic          wb_clk    = 1'b0;
   logic          wb_rst    = 1'b0;
   logic [17:0]   wb_adr_i  = '0;
   logic [31:0]   wb_dat_i  = '0;
   logic [3:0]    wb_sel_i  = 4'hF;
   logic          wb_we_i   = 1'b0;
   logic          wb_cyc_i  = 1'b0;
   logic          wb_stb_i  = 1'b0;
   logic [2:0]    wb_cti_i  = '0;
   logic [1:0]    wb_bte_i  = '0;
   logic [31:0]   wb_dat_o;
   logic          wb_ack_o;
   logic          wb_err_o;
   logic          wb_rty_o;
   logic [NC-1:0] ipi_irq_i = '0;
   logic [NS-1:0] src_irq_i = '0;
   logic [NC-1:0] cpu_irq_o;

   int errors = 0;
   int checks = 0;

   ipi_irq_ctrl #(
      .NUM_CORES (NC),
      .NUM_SRC   (NS)
   ) dut (
      .wb_clk    (wb_clk),
      .wb_rst    (wb_rst),
      .wb_adr_i  (wb_adr_i),
      .wb_dat_i  (wb_dat_i),
      .wb_sel_i  (wb_sel_i),
      .wb_we_i   (wb_we_i),
      .wb_cyc_i  (wb_cyc_i),
      .wb_stb_i  (wb_stb_i),
      .wb_cti_i  (wb_cti_i),
      .wb_bte_i  (wb_bte_i),
      .wb_dat_o  (wb_dat_o),
      .wb_ack_o  (wb_ack_o),
      .wb_err_o  (wb_err_o),
      .wb_rty_o  (wb_rty_o),
      .ipi_irq_i (ipi_irq_i),
      .src_irq_i (src_irq_i),
      .cpu_irq_o (cpu_irq_o)
   );

   always #5 wb_clk = ~wb_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Reference model: register contents per core, plus the last three samples of
   // src_irq_i taken at clock edges (a source is seen by the controller two
   // samples late, and its rise is judged against the sample before that).
   // ---------------------------------------------------------------------------
   logic [W-1:0]  m_mask [NC];
   logic [W-1:0]  m_mode [NC];
   logic [W-1:0]  m_pend [NC];
   logic [NC-1:0] m_irq;
   logic          m_ack;
   logic          m_err;
   logic [31:0]   m_dat;
   logic [NS-1:0] hs [3];

   task automatic model_reset();
      for (int c = 0; c < NC; c++) begin
         m_mask[c] = '0;
         m_mode[c] = '0;
         m_pend[c] = '0;
      end
      for (int i = 0; i < 3; i++) hs[i] = '0;
      m_irq = '0;
      m_ack = 1'b0;
      m_err = 1'b0;
      m_dat = '0;
   endtask

   // Advances one clock: predicts the post-edge state from the rules, then waits
   // for the edge and settles 1 time unit past it.
   task automatic step();
      logic [W-1:0]  n_mask [NC];
      logic [W-1:0]  n_mode [NC];
      logic [W-1:0]  n_pend [NC];
      logic [W-1:0]  clr;
      logic [NC-1:0] n_irq;
      logic          n_ack, n_err, req, ok;
      logic [31:0]   n_dat;
      logic [NS-1:0] src_now;
      int            core, rsel;

      src_now = src_irq_i;
      req     = wb_cyc_i && wb_stb_i && !m_ack && !m_err;
      core    = int'(wb_adr_i[17:4]);
      rsel    = int'(wb_adr_i[3:2]);
      ok      = core < NC;
      n_ack   = req && ok;
      n_err   = req && !ok;
      n_dat   = m_dat;
      if (req) begin
         n_dat = '0;
         if (ok) begin
            case (rsel)
               0:       n_dat = 32'(m_mask[core]);
               1:       n_dat = 32'(m_pend[core]);
               2:       n_dat = 32'(m_mode[core]);
               default: n_dat = 32'(m_pend[core] & m_mask[core]);
            endcase
         end
      end

      for (int c = 0; c < NC; c++) begin
         n_mask[c] = m_mask[c];
         n_mode[c] = m_mode[c];
         n_irq[c]  = |(m_pend[c] & m_mask[c]);
         clr       = '0;
         if (req && ok && wb_we_i && core == c) begin
            case (rsel)
               0:       n_mask[c] = wb_dat_i[W-1:0];
               1:       clr       = wb_dat_i[W-1:0] & m_mode[c];
               2:       n_mode[c] = wb_dat_i[W-1:0] & ~(W'(1));
               default: ;
            endcase
         end
         for (int b = 0; b < W; b++) begin
            if (b == 0)                              n_pend[c][b] = ipi_irq_i[c];
            else if (!m_mode[c][b])                  n_pend[c][b] = hs[1][b-1];
            else if (hs[1][b-1] && !hs[2][b-1])      n_pend[c][b] = 1'b1;
            else if (clr[b])                         n_pend[c][b] = 1'b0;
            else                                     n_pend[c][b] = m_pend[c][b];
         end
      end

      @(posedge wb_clk);
      if (!wb_rst) begin
         model_reset();
      end else begin
         for (int c = 0; c < NC; c++) begin
            m_mask[c] = n_mask[c];
            m_mode[c] = n_mode[c];
            m_pend[c] = n_pend[c];
         end
         m_irq = n_irq;
         m_ack = n_ack;
         m_err = n_err;
         m_dat = n_dat;
         hs[2] = hs[1];
         hs[1] = hs[0];
         hs[0] = src_now;
      end
      #1;
   endtask

   task automatic wb_xfer(input int core, input int rsel, input logic we, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic got_ack, output logic got_err);
      wb_adr_i = 18'((core << 4) | (rsel << 2));
      wb_we_i  = we;
      wb_dat_i = wdata;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      got_ack  = 1'b0;
      got_err  = 1'b0;
      rdata    = '0;
      for (int i = 0; i < 4 && !(got_ack || got_err); i++) begin
         step();
         got_ack = wb_ack_o;
         got_err = wb_err_o;
         rdata   = wb_dat_o;
      end
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      if (!(got_ack || got_err)) begin
         checks++;
         errors++;
         $display("FAIL wb_timeout: no ack/err for core %0d reg %0d", core, rsel);
      end
   endtask

   task automatic wb_wr(input int core, input int rsel, input logic [31:0] wdata);
      logic [31:0] rd;
      logic a, e;
      wb_xfer(core, rsel, 1'b1, wdata, rd, a, e);
   endtask

   task automatic wb_rd(input int core, input int rsel, output logic [31:0] rdata);
      logic a, e;
      wb_xfer(core, rsel, 1'b0, '0, rdata, a, e);
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      logic [31:0] rd;
      logic        a, e;
      wb_rst = 1'b0;
      model_reset();
      repeat (3) step();
      checks++; if (cpu_irq_o !== 2'b00) begin errors++; $display("FAIL reset_irq: got %b want 00", cpu_irq_o); end
      checks++; if (wb_ack_o !== 1'b0)   begin errors++; $display("FAIL reset_ack: got %b want 0", wb_ack_o); end
      checks++; if (wb_err_o !== 1'b0)   begin errors++; $display("FAIL reset_err: got %b want 0", wb_err_o); end
      checks++; if (wb_dat_o !== 32'h0)  begin errors++; $display("FAIL reset_dat: got %h want 0", wb_dat_o); end
      checks++; if (wb_rty_o !== 1'b0)   begin errors++; $display("FAIL reset_rty: got %b want 0", wb_rty_o); end
      wb_rst = 1'b1;
      step();
      for (int c = 0; c < NC; c++) begin
         for (int r = 0; r < 4; r++) begin
            wb_xfer(c, r, 1'b0, '0, rd, a, e);
            checks++;
            if (a !== 1'b1 || rd !== 32'h0) begin
               errors++;
               $display("FAIL reset_reg c%0d r%0d: got ack=%b dat=%h want ack=1 dat=0", c, r, a, rd);
            end
         end
      end
      checks++; if (cpu_irq_o !== 2'b00) begin errors++; $display("FAIL reset_irq_after: got %b want 00", cpu_irq_o); end
   endtask

   task automatic test_reg_access();
      logic [31:0] rd;
      wb_wr(1, 2, 32'hFFFF_FFFF);
      wb_rd(1, 2, rd);
      checks++; if (rd !== 32'h1FE) begin errors++; $display("FAIL mode_bit0_forced: got %h want 1fe", rd); end
      wb_wr(1, 0, 32'hFFFF_FFFF);
      wb_rd(1, 0, rd);
      checks++; if (rd !== 32'h1FF) begin errors++; $display("FAIL mask_upper_zero: got %h want 1ff", rd); end
      wb_wr(1, 3, 32'h0000_00FF);
      wb_rd(1, 0, rd);
      checks++; if (rd !== 32'h1FF) begin errors++; $display("FAIL active_readonly: got %h want 1ff", rd); end
      wb_rd(1, 3, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL active_idle: got %h want 0", rd); end
      wb_wr(1, 2, 32'h0);
      wb_wr(1, 0, 32'h0);
      wb_rd(1, 2, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mode_restore: got %h want 0", rd); end
   endtask

   task automatic test_ipi_level();
      logic [31:0] rd;
      wb_wr(0, 0, 32'h1);
      ipi_irq_i[0] = 1'b1;
      step();
      checks++; if (cpu_irq_o[0] !== 1'b0) begin errors++; $display("FAIL ipi_rise_1cyc: got %b want 0", cpu_irq_o[0]); end
      step();
      checks++; if (cpu_irq_o[0] !== 1'b1) begin errors++; $display("FAIL ipi_rise_2cyc: got %b want 1", cpu_irq_o[0]); end
      wb_rd(0, 1, rd);
      checks++; if (rd !== 32'h1) begin errors++; $display("FAIL ipi_pend: got %h want 1", rd); end
      wb_wr(0, 1, 32'h1);
      wb_rd(0, 1, rd);
      checks++; if (rd !== 32'h1) begin errors++; $display("FAIL ipi_w1c_ignored: got %h want 1", rd); end
      wb_rd(0, 3, rd);
      checks++; if (rd !== 32'h1) begin errors++; $display("FAIL ipi_active: got %h want 1", rd); end
      ipi_irq_i[0] = 1'b0;
      step();
      checks++; if (cpu_irq_o[0] !== 1'b1) begin errors++; $display("FAIL ipi_fall_1cyc: got %b want 1", cpu_irq_o[0]); end
      step();
      checks++; if (cpu_irq_o[0] !== 1'b0) begin errors++; $display("FAIL ipi_fall_2cyc: got %b want 0", cpu_irq_o[0]); end
   endtask

   task automatic test_src_edge();
      logic [31:0] rd;
      logic        a, e;
      wb_wr(1, 2, 32'h4);
      wb_wr(1, 0, 32'h4);
      src_irq_i[1] = 1'b1;
      step();
      src_irq_i[1] = 1'b0;
      step();
      step();
      checks++; if (cpu_irq_o[1] !== 1'b0) begin errors++; $display("FAIL src_rise_3cyc: got %b want 0", cpu_irq_o[1]); end
      step();
      checks++; if (cpu_irq_o[1] !== 1'b1) begin errors++; $display("FAIL src_rise_4cyc: got %b want 1", cpu_irq_o[1]); end
      repeat (6) step();
      checks++; if (cpu_irq_o[1] !== 1'b1) begin errors++; $display("FAIL src_edge_hold: got %b want 1", cpu_irq_o[1]); end
      wb_rd(1, 1, rd);
      checks++; if (rd !== 32'h4) begin errors++; $display("FAIL src_edge_pend: got %h want 4", rd); end
      wb_xfer(1, 1, 1'b1, 32'h4, rd, a, e);
      checks++; if (cpu_irq_o[1] !== 1'b1) begin errors++; $display("FAIL w1c_ack_cycle: got %b want 1", cpu_irq_o[1]); end
      step();
      checks++; if (cpu_irq_o[1] !== 1'b0) begin errors++; $display("FAIL w1c_drop: got %b want 0", cpu_irq_o[1]); end
   endtask

   task automatic test_set_wins();
      logic [31:0] rd;
      src_irq_i[1] = 1'b1;
      step();
      step();
      wb_adr_i = 18'((1 << 4) | (1 << 2));
      wb_dat_i = 32'h4;
      wb_we_i  = 1'b1;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      step();
      checks++; if (wb_ack_o !== 1'b1) begin errors++; $display("FAIL set_wins_ack: got %b want 1", wb_ack_o); end
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      wb_rd(1, 1, rd);
      checks++; if (rd !== 32'h4) begin errors++; $display("FAIL set_wins_pend: got %h want 4", rd); end
      src_irq_i[1] = 1'b0;
      repeat (3) step();
      wb_wr(1, 1, 32'h4);
      wb_rd(1, 1, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL plain_w1c: got %h want 0", rd); end
   endtask

   task automatic test_bad_core();
      logic [31:0] rd;
      logic        a, e;
      wb_xfer(NC, 0, 1'b1, 32'h1FF, rd, a, e);
      checks++;
      if (e !== 1'b1 || a !== 1'b0 || rd !== 32'h0) begin
         errors++;
         $display("FAIL bad_core_resp: got ack=%b err=%b dat=%h want ack=0 err=1 dat=0", a, e, rd);
      end
      step();
      checks++; if (wb_err_o !== 1'b0) begin errors++; $display("FAIL bad_core_err_pulse: got %b want 0", wb_err_o); end
      wb_xfer(16383, 3, 1'b0, '0, rd, a, e);
      checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL bad_core_read: got err=%b dat=%h want err=1 dat=0", e, rd); end
      wb_rd(0, 0, rd);
      checks++; if (rd !== 32'h1) begin errors++; $display("FAIL bad_core_mask0: got %h want 1", rd); end
      wb_rd(1, 0, rd);
      checks++; if (rd !== 32'h4) begin errors++; $display("FAIL bad_core_mask1: got %h want 4", rd); end
   endtask

   task automatic test_random();
      int core, bit_idx;
      for (int n = 0; n < 600; n++) begin
         if (wb_cyc_i && (wb_ack_o || wb_err_o)) begin
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
            wb_we_i  = 1'b0;
         end else if (!wb_cyc_i && $urandom_range(0, 2) == 0) begin
            core     = ($urandom_range(0, 9) == 0) ? NC : int'($urandom_range(0, NC - 1));
            wb_adr_i = 18'((core << 4) | (int'($urandom_range(0, 3)) << 2));
            wb_we_i  = 1'($urandom_range(0, 1));
            wb_dat_i = $urandom;
            wb_cyc_i = 1'b1;
            wb_stb_i = 1'b1;
         end
         if ($urandom_range(0, 7) == 0) begin
            bit_idx = int'($urandom_range(0, NC - 1));
            ipi_irq_i[bit_idx] = ~ipi_irq_i[bit_idx];
         end
         if ($urandom_range(0, 2) == 0) begin
            bit_idx = int'($urandom_range(0, NS - 1));
            src_irq_i[bit_idx] = ~src_irq_i[bit_idx];
         end
         step();
         checks++; if (cpu_irq_o !== m_irq) begin errors++; $display("FAIL rand_irq @%0d: got %b want %b", n, cpu_irq_o, m_irq); end
         checks++; if (wb_ack_o !== m_ack)  begin errors++; $display("FAIL rand_ack @%0d: got %b want %b", n, wb_ack_o, m_ack); end
         checks++; if (wb_err_o !== m_err)  begin errors++; $display("FAIL rand_err @%0d: got %b want %b", n, wb_err_o, m_err); end
         if (m_ack || m_err) begin
            checks++;
            if (wb_dat_o !== m_dat) begin errors++; $display("FAIL rand_dat @%0d: got %h want %h", n, wb_dat_o, m_dat); end
         end
      end
      for (int i = 0; i < 3 && wb_cyc_i && !(wb_ack_o || wb_err_o); i++) step();
      wb_cyc_i  = 1'b0;
      wb_stb_i  = 1'b0;
      wb_we_i   = 1'b0;
      ipi_irq_i = '0;
      src_irq_i = '0;
      repeat (4) step();
   endtask

   task automatic test_reset_async();
      logic [31:0] rd;
      logic        a, e;
      for (int c = 0; c < NC; c++) begin
         wb_wr(c, 2, 32'h0);
         wb_wr(c, 0, 32'h1FF);
      end
      src_irq_i = '1;
      repeat (6) step();
      checks++; if (cpu_irq_o !== 2'b11) begin errors++; $display("FAIL pre_reset_irq: got %b want 11", cpu_irq_o); end
      wb_adr_i = 18'h0;
      wb_dat_i = 32'h0;
      wb_we_i  = 1'b1;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      #2;
      wb_rst = 1'b0;
      #1;
      model_reset();
      checks++; if (cpu_irq_o !== 2'b00) begin errors++; $display("FAIL async_reset_irq: got %b want 00", cpu_irq_o); end
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL reset_drops_access: got %b want 0", wb_ack_o); end
      end
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      wb_rst   = 1'b1;
      repeat (5) step();
      checks++; if (cpu_irq_o !== 2'b00) begin errors++; $display("FAIL post_reset_masked: got %b want 00", cpu_irq_o); end
      wb_rd(0, 1, rd);
      checks++; if (rd !== 32'h1FE) begin errors++; $display("FAIL post_reset_pend: got %h want 1fe", rd); end
      wb_xfer(0, 0, 1'b1, 32'h1FF, rd, a, e);
      checks++; if (cpu_irq_o !== 2'b00) begin errors++; $display("FAIL remask_ack_cycle: got %b want 00", cpu_irq_o); end
      step();
      checks++; if (cpu_irq_o !== 2'b01) begin errors++; $display("FAIL remask_irq: got %b want 01", cpu_irq_o); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_reg_access();
      test_ipi_level();
      test_src_edge();
      test_set_wins();
      test_bad_core();
      test_random();
      test_reset_async();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ipi_irq_ctrl.md
Name: ipi_irq_ctrl

Overview:
Per-core interrupt controller directly downstream of the IPI block. Merges each core's IPI line with shared peripheral interrupt lines. Applies per-core mask, edge/level mode and pending latches, and drives one registered interrupt per CPU. Software accesses it through a Wishbone slave on the same bus segment as the IPI block.

Parameters:
NUM_CORES, 2, number of cores; one register bank and one irq output each
NUM_SRC, 8, number of shared peripheral interrupt lines (1..31)

Ports:
wb_clk  in  1  bus/system clock
wb_rst  in  1  reset; asynchronous, active-low
wb_adr_i  in  18  byte address; [17:4] core index, [3:2] register select
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte selects; ignored, all accesses are full-word
wb_we_i  in  1  write enable
wb_cyc_i  in  1  cycle
wb_stb_i  in  1  strobe
wb_cti_i  in  3  ignored; every access is classic
wb_bte_i  in  2  ignored
wb_dat_o  out  32  read data
wb_ack_o  out  1  acknowledge
wb_err_o  out  1  error
wb_rty_o  out  1  constant 0
ipi_irq_i  in  NUM_CORES  per-core IPI lines from the IPI block; synchronous to wb_clk
src_irq_i  in  NUM_SRC  shared peripheral interrupts; asynchronous
cpu_irq_o  out  NUM_CORES  per-core interrupt to CPU

Behaviour:
- Vector width W = NUM_SRC+1. Bit 0 is the IPI; bit k (k≥1) is src_irq_i[k-1]. Upper register bits read 0, writes to them are ignored.
- Per-core registers, selected by [3:2]:
  - 0 MASK: RW, reset 0.
  - 1 PEND: read; a write is write-1-to-clear on edge-mode bits only.
  - 2 MODE: RW, 1 = edge, 0 = level, reset 0. Bit 0 is forced to level (reads 0).
  - 3 ACTIVE: read-only, PEND & MASK.
- src_irq_i passes through a 2-flop synchronizer (reset 0), followed by one history flop for edge detection. ipi_irq_i is used directly.
- Level bit: PEND follows the input level, registered one cycle after the input.
- Edge bit: a rising edge of the synchronized input sets PEND. PEND stays set until a W1C. If a set and a clear hit the same cycle, set wins.
- Switching a bit from edge to level: PEND takes the level on the next cycle. Switching level to edge: PEND holds, and is not cleared by the switch.
- cpu_irq_o[c] = registered |(PEND & MASK).
  - Latency: IPI rise -> PEND +1 cycle -> cpu_irq_o +2 cycles.
  - src rise -> PEND +3 cycles -> cpu_irq_o +4 cycles.
  - MASK write -> cpu_irq_o change 1 cycle after ack.
- Wishbone response timing: registered, one response per access; asserts the cycle after cyc&stb, deasserts the following cycle (ack <= cyc&stb&!ack&!err; err likewise).
- Core index ≥ NUM_CORES: wb_err_o instead of wb_ack_o, with no state change and wb_dat_o = 0.
- Writes take effect on the ack cycle. wb_dat_o is registered on the same edge that asserts ack.
- Reset values: all registers, synchronizers, cpu_irq_o, wb_ack_o, wb_err_o and wb_dat_o are 0. Reset mid-transfer drops the access with no ack. A pending IPI is not retained through reset; the IPI block re-drives it.
- Level-mode IPI (bit 0) is acknowledged through the IPI block's own CTRL ACK write, never here.

Decomposition:
- Shared package: register offsets (MASK=0, PEND=1, MODE=2, ACTIVE=3) and the core-index field position [17:4]. Both are shared with the IPI block's address map.
- One sub-module: ipi_irq_sync. Parameterised width; 2-flop synchronizer plus history flop; outputs sync level and rise pulse. Instantiated once for src_irq_i.

Test Plan:
1. Reset, then read all registers of cores 0 and 1. All read 0, cpu_irq_o = 0.
2. Core0: MASK = 0x1. Pulse ipi_irq_i[0] high, hold until IPI ACK. PEND[0] = 1 after 1 cycle, cpu_irq_o[0] = 1 after 2 cycles. Drop ipi_irq_i[0]; cpu_irq_o[0] = 0 two cycles later.
3. Core1: MODE = 0x4, MASK = 0x4. Apply a 1-cycle-wide-after-sync pulse on src_irq_i[1]. cpu_irq_o[1] rises 4 cycles later and stays high. Write PEND = 0x4; cpu_irq_o[1] drops 1 cycle after ack.
4. Edge in progress on bit 2 in the same cycle as a W1C of bit 2 -> PEND[2] remains 1.
5. Access with adr[17:4] = NUM_CORES (e.g. 0x20 for 2 cores) -> wb_err_o pulses for 1 cycle, wb_ack_o stays 0, no register changes.
6. Assert wb_rst low while src_irq_i = all-1 and MASK = 0x1FF -> cpu_irq_o = 0 asynchronously. After release, level sources re-raise cpu_irq_o only once MASK is rewritten.
